// File: rtl/rename_pkg.sv
// Shared sizes, types and helpers for the register rename stage.
package rename_pkg;

   localparam int ARCH_REGS = 32;
   localparam int PHYS_REGS = 64;
   localparam int AREG_W    = 5;
   localparam int PREG_W    = 6;

   typedef logic [AREG_W-1:0] areg_t;
   typedef logic [PREG_W-1:0] preg_t;
   typedef logic [PREG_W:0]   pcnt_t;

   typedef struct packed {
      preg_t prs1;
      preg_t prs2;
      preg_t prd;
      preg_t old_prd;
      logic  rd_wr;
   } renamed_uop_t;

   // Number of set bits in a free-set vector; used when the free set is bulk-loaded.
   function automatic pcnt_t count_ones(input logic [PHYS_REGS-1:0] vec);
      pcnt_t n;
      n = '0;
      for (int i = 0; i < PHYS_REGS; i++) begin
         n = n + pcnt_t'(vec[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/preg_free_list.sv
// Physical register free list: bit-vector free set, lowest-index allocation,
// running count, single return port and a bulk-load port used for recovery.
// Illegal returns (preg 0 or an already-free preg) leave the state untouched.
module preg_free_list
   import rename_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 alloc_i,
   output logic [PREG_W-1:0]    alloc_preg_o,
   input  logic                 free_valid_i,
   input  logic [PREG_W-1:0]    free_preg_i,
   input  logic                 load_i,
   input  logic [PHYS_REGS-1:0] load_vec_i,
   output logic [PREG_W:0]      count_o
);

   localparam logic [PHYS_REGS-1:0] RESET_FREE =
      {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
   localparam pcnt_t RESET_COUNT = pcnt_t'(PHYS_REGS - ARCH_REGS);

   logic [PHYS_REGS-1:0] free_q, free_d;
   pcnt_t                count_q, count_d;
   preg_t                pick_s;
   logic                 alloc_fire_s;
   logic                 free_legal_s;

   // Lowest-index free preg; scanning downward lets the lowest set bit win.
   always_comb begin
      pick_s = '0;
      for (int i = PHYS_REGS-1; i >= 0; i--) begin
         pick_s = free_q[i] ? PREG_W'(i) : pick_s;
      end
   end

   assign alloc_fire_s = alloc_i && (|free_q);
   assign free_legal_s = free_valid_i && (free_preg_i != '0) && !free_q[free_preg_i];

   // Next free set and count: a bulk load replaces everything, otherwise apply alloc then free.
   always_comb begin
      free_d  = free_q;
      count_d = count_q;
      if (load_i) begin
         free_d  = load_vec_i;
         count_d = count_ones(load_vec_i);
      end else begin
         if (alloc_fire_s) begin
            free_d[pick_s] = 1'b0;
         end else begin
            free_d = free_d;
         end
         if (free_legal_s) begin
            free_d[free_preg_i] = 1'b1;
         end else begin
            free_d = free_d;
         end
         count_d = count_q - pcnt_t'(alloc_fire_s) + pcnt_t'(free_legal_s);
      end
   end

   // Free-set and count state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         free_q  <= RESET_FREE;
         count_q <= RESET_COUNT;
      end else begin
         free_q  <= free_d;
         count_q <= count_d;
      end
   end

   assign alloc_preg_o = pick_s;
   assign count_o      = count_q;

   preg_free_list_chk u_chk (
      .clk          (clk),
      .reset        (reset),
      .free_valid_i (free_valid_i),
      .free_preg_i  (free_preg_i),
      .free_vec_i   (free_q)
   );

endmodule

// File: rtl/preg_free_list_chk.sv
// Protocol checker for the physical register free list: a returned preg must be
// nonzero and currently busy.
module preg_free_list_chk
   import rename_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 free_valid_i,
   input  logic [PREG_W-1:0]    free_preg_i,
   input  logic [PHYS_REGS-1:0] free_vec_i
);

   illegal_free_a : assert property (@(posedge clk) disable iff (reset)
      free_valid_i |-> ((free_preg_i != '0) && !free_vec_i[free_preg_i]));

endmodule

// File: rtl/register_rename.sv
// Register rename stage feeding the reorder buffer: speculative RAT, free-list
// allocation and a one-entry output register.
// Optional feature macro RENAME_RECOVERY_EN adds a committed RAT plus flush
// recovery (ports flush, free_arch_rd, commit_preg).
module register_rename
   import rename_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [AREG_W-1:0] in_rs1,
   input  logic [AREG_W-1:0] in_rs2,
   input  logic [AREG_W-1:0] in_rd,
   input  logic              in_rd_wr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PREG_W-1:0] out_prs1,
   output logic [PREG_W-1:0] out_prs2,
   output logic [PREG_W-1:0] out_prd,
   output logic [PREG_W-1:0] out_old_prd,
   output logic              out_rd_wr,
   input  logic              free_valid,
   input  logic [PREG_W-1:0] free_preg,
   output logic [PREG_W:0]   free_count
`ifdef RENAME_RECOVERY_EN
   ,
   input  logic              flush,
   input  logic [AREG_W-1:0] free_arch_rd,
   input  logic [PREG_W-1:0] commit_preg
`endif
);

   preg_t        rat_q [ARCH_REGS];
   preg_t        rat_d [ARCH_REGS];
   renamed_uop_t out_q, out_d;
   logic         out_valid_q, out_valid_d;

   preg_t                fl_pick_s;
   pcnt_t                fl_count_s;
   logic                 fl_load_s;
   logic [PHYS_REGS-1:0] fl_load_vec_s;
   logic                 flush_s;
   logic                 in_ready_s;
   logic                 accept_s;
   logic                 wr_eff_s;
   logic                 alloc_s;
   renamed_uop_t         uop_s;

`ifdef RENAME_RECOVERY_EN
   preg_t                crat_q [ARCH_REGS];
   preg_t                crat_d [ARCH_REGS];
   logic [PHYS_REGS-1:0] mapped_s;

   assign flush_s = flush;

   // Committed RAT follows the ROB: each commit records the retiring destination mapping.
   always_comb begin
      crat_d = crat_q;
      if (free_valid && (free_arch_rd != '0)) begin
         crat_d[free_arch_rd] = commit_preg;
      end else begin
         crat_d = crat_d;
      end
   end

   // Pregs referenced by the updated committed RAT; everything else is free after a flush.
   always_comb begin
      mapped_s = '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
         mapped_s[crat_d[i]] = 1'b1;
      end
   end

   assign fl_load_s     = flush;
   assign fl_load_vec_s = ~mapped_s;

   // Committed RAT register; resets to the identity mapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            crat_q[i] <= PREG_W'(i);
         end
      end else begin
         crat_q <= crat_d;
      end
   end
`else
   assign flush_s       = 1'b0;
   assign fl_load_s     = 1'b0;
   assign fl_load_vec_s = '0;
`endif

   // Accept only with room in the output register and at least one free preg.
   assign in_ready_s = (!out_valid_q || out_ready) && (fl_count_s != '0) && !flush_s;
   assign accept_s   = in_valid && in_ready_s;
   assign wr_eff_s   = in_rd_wr && (in_rd != '0);
   assign alloc_s    = accept_s && wr_eff_s;

   // Renamed view of the incoming instruction; sources read the RAT before rd is remapped.
   always_comb begin
      uop_s.prs1    = rat_q[in_rs1];
      uop_s.prs2    = rat_q[in_rs2];
      uop_s.prd     = wr_eff_s ? fl_pick_s : '0;
      uop_s.old_prd = wr_eff_s ? rat_q[in_rd] : '0;
      uop_s.rd_wr   = wr_eff_s;
   end

   // Next RAT and output register; flush restores the committed mapping and drops the output.
   always_comb begin
      rat_d       = rat_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (alloc_s) begin
         rat_d[in_rd] = fl_pick_s;
      end else begin
         rat_d = rat_d;
      end
      if (accept_s) begin
         out_d       = uop_s;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
`ifdef RENAME_RECOVERY_EN
      if (flush) begin
         rat_d       = crat_d;
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_d;
      end
`endif
   end

   // Speculative RAT and output register state.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            rat_q[i] <= PREG_W'(i);
         end
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         rat_q       <= rat_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   preg_free_list u_free_list (
      .clk          (clk),
      .reset        (reset),
      .alloc_i      (alloc_s),
      .alloc_preg_o (fl_pick_s),
      .free_valid_i (free_valid),
      .free_preg_i  (free_preg),
      .load_i       (fl_load_s),
      .load_vec_i   (fl_load_vec_s),
      .count_o      (fl_count_s)
   );

   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_q;
   assign out_prs1    = out_q.prs1;
   assign out_prs2    = out_q.prs2;
   assign out_prd     = out_q.prd;
   assign out_old_prd = out_q.old_prd;
   assign out_rd_wr   = out_q.rd_wr;
   assign free_count  = fl_count_s;

endmodule

// File: tb/tb_register_rename.sv
// Directed self-checking bench for register_rename (default build, no recovery).
module tb_register_rename;
   import rename_pkg::*;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [AREG_W-1:0] in_rs1, in_rs2, in_rd;
   logic              in_rd_wr;
   logic              out_valid;
   logic              out_ready;
   logic [PREG_W-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
   logic              out_rd_wr;
   logic              free_valid;
   logic [PREG_W-1:0] free_preg;
   logic [PREG_W:0]   free_count;

   int n_cmp = 0;
   int n_err = 0;

   register_rename dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rs1      (in_rs1),
      .in_rs2      (in_rs2),
      .in_rd       (in_rd),
      .in_rd_wr    (in_rd_wr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_prs1    (out_prs1),
      .out_prs2    (out_prs2),
      .out_prd     (out_prd),
      .out_old_prd (out_old_prd),
      .out_rd_wr   (out_rd_wr),
      .free_valid  (free_valid),
      .free_preg   (free_preg),
      .free_count  (free_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input logic v, input int rs1, input int rs2, input int rd, input logic wr);
      in_valid = v;
      in_rs1   = AREG_W'(rs1);
      in_rs2   = AREG_W'(rs2);
      in_rd    = AREG_W'(rd);
      in_rd_wr = wr;
   endtask

   initial begin
      reset      = 1'b1;
      out_ready  = 1'b1;
      free_valid = 1'b0;
      free_preg  = '0;
      set_in(1'b0, 0, 0, 0, 1'b0);
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_free_count", free_count, 32);
      chk("rst_prd", out_prd, 0);
      chk("rst_old_prd", out_old_prd, 0);
      chk("rst_prs1", out_prs1, 0);
      chk("rst_in_ready", in_ready, 1);

      // add x1 <- x2, x3
      set_in(1'b1, 2, 3, 1, 1'b1);
      #1 chk("t1_in_ready", in_ready, 1);
      cyc();
      chk("t1_out_valid", out_valid, 1);
      chk("t1_prs1", out_prs1, 2);
      chk("t1_prs2", out_prs2, 3);
      chk("t1_prd", out_prd, 32);
      chk("t1_old_prd", out_old_prd, 1);
      chk("t1_rd_wr", out_rd_wr, 1);
      chk("t1_free_count", free_count, 31);

      // reset wins over a valid instruction in the same cycle
      set_in(1'b1, 0, 0, 5, 1'b1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      set_in(1'b0, 0, 0, 0, 1'b0);
      #1;
      chk("rst2_free_count", free_count, 32);
      chk("rst2_out_valid", out_valid, 0);
      chk("rst2_prd", out_prd, 0);

      // back-to-back x1 <- x1
      set_in(1'b1, 1, 1, 1, 1'b1);
      cyc();
      chk("t2a_prs1", out_prs1, 1);
      chk("t2a_prd", out_prd, 32);
      chk("t2a_old_prd", out_old_prd, 1);
      cyc();
      chk("t2b_prs1", out_prs1, 32);
      chk("t2b_prs2", out_prs2, 32);
      chk("t2b_prd", out_prd, 33);
      chk("t2b_old_prd", out_old_prd, 32);
      chk("t2b_free_count", free_count, 30);

      // rd = x0: no allocation
      set_in(1'b1, 0, 5, 0, 1'b1);
      cyc();
      chk("x0_prs1", out_prs1, 0);
      chk("x0_prs2", out_prs2, 5);
      chk("x0_prd", out_prd, 0);
      chk("x0_old_prd", out_old_prd, 0);
      chk("x0_rd_wr", out_rd_wr, 0);
      chk("x0_free_count", free_count, 30);

      // no write: no allocation
      set_in(1'b1, 4, 4, 4, 1'b0);
      cyc();
      chk("nowr_prs1", out_prs1, 4);
      chk("nowr_prd", out_prd, 0);
      chk("nowr_rd_wr", out_rd_wr, 0);
      chk("nowr_free_count", free_count, 30);

      // stall: output held while out_ready is low
      set_in(1'b1, 1, 2, 2, 1'b1);
      cyc();
      chk("t3_prs1", out_prs1, 33);
      chk("t3_prd", out_prd, 34);
      chk("t3_old_prd", out_old_prd, 2);
      chk("t3_free_count", free_count, 29);
      out_ready = 1'b0;
      set_in(1'b1, 1, 3, 3, 1'b1);
      #1 chk("t3_stall_in_ready", in_ready, 0);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("t3_hold_valid", out_valid, 1);
         chk("t3_hold_prd", out_prd, 34);
         chk("t3_hold_prs1", out_prs1, 33);
         chk("t3_hold_free_count", free_count, 29);
         chk("t3_hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      #1 chk("t3_release_in_ready", in_ready, 1);
      cyc();
      chk("t3_next_prd", out_prd, 35);
      chk("t3_next_old_prd", out_old_prd, 3);
      chk("t3_next_prs2", out_prs2, 3);
      chk("t3_next_free_count", free_count, 28);

      // drain the free list through x10
      for (int i = 0; i < 28; i++) begin
         set_in(1'b1, 1, 0, 10, 1'b1);
         cyc();
         chk("t4_prd", out_prd, 36 + i);
         chk("t4_old_prd", out_old_prd, (i == 0) ? 10 : 35 + i);
      end
      chk("t4_free_count", free_count, 0);
      set_in(1'b1, 0, 0, 11, 1'b1);
      #1 chk("t4_empty_in_ready", in_ready, 0);
      cyc();
      chk("t4_empty_out_valid", out_valid, 0);
      chk("t4_empty_free_count", free_count, 0);
      free_valid = 1'b1;
      free_preg  = 6'd5;
      #1 chk("t4_free_cycle_in_ready", in_ready, 0);
      cyc();
      free_valid = 1'b0;
      #1;
      chk("t4_after_free_count", free_count, 1);
      chk("t4_after_free_in_ready", in_ready, 1);
      cyc();
      chk("t4_realloc_prd", out_prd, 5);
      chk("t4_realloc_old_prd", out_old_prd, 11);
      chk("t4_realloc_free_count", free_count, 0);

      // same-cycle alloc and free
      set_in(1'b0, 0, 0, 0, 1'b0);
      free_valid = 1'b1;
      free_preg  = 6'd6;
      cyc();
      chk("t5_free6_count", free_count, 1);
      set_in(1'b1, 10, 0, 12, 1'b1);
      free_preg = 6'd7;
      #1 chk("t5_in_ready", in_ready, 1);
      cyc();
      chk("t5_prd", out_prd, 6);
      chk("t5_old_prd", out_old_prd, 12);
      chk("t5_prs1", out_prs1, 63);
      chk("t5_free_count", free_count, 1);
      free_valid = 1'b0;
      set_in(1'b1, 0, 0, 13, 1'b1);
      cyc();
      chk("t5_next_prd", out_prd, 7);
      chk("t5_next_old_prd", out_old_prd, 13);
      chk("t5_next_free_count", free_count, 0);
      set_in(1'b0, 0, 0, 0, 1'b0);
      cyc();
      chk("t5_idle_out_valid", out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
